// File: rtl/cam_config_seq_if.sv
// SCCB write-request handshake between the config sequencer and the SCCB master.
interface cam_config_seq_if;
  logic       o_sccb_start;
  logic [7:0] o_sccb_addr;
  logic [7:0] o_sccb_data;
  logic       i_sccb_ready;
  logic       i_sccb_done;
  logic       i_sccb_nack;

  // Sequencer side: issues requests, receives completion status.
  modport master (
    output o_sccb_start, o_sccb_addr, o_sccb_data,
    input  i_sccb_ready, i_sccb_done, i_sccb_nack
  );

  // SCCB master side: accepts requests, reports completion status.
  modport slave (
    input  o_sccb_start, o_sccb_addr, o_sccb_data,
    output i_sccb_ready, i_sccb_done, i_sccb_nack
  );
endinterface

// File: rtl/cam_config_seq.sv
// Walks the OV7670 init ROM and issues one SCCB write per {reg, data} entry,
// honouring delay/end markers and retrying NACKed writes.
module cam_config_seq #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned DELAY_MS  = 10,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  output logic [7:0]              o_rom_addr,
  input  logic [15:0]             i_rom_data,
  cam_config_seq_if.master        sccb,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int unsigned DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
  localparam int unsigned CNT_W     = $clog2(DELAY_CYC + 1);
  localparam int unsigned RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [15:0]        END_MARK   = 16'hFFFF;
  localparam logic [15:0]        DELAY_MARK = 16'hFFF0;
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(DELAY_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_REQ, S_WAIT, S_DELAY, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         rom_addr_d;
  logic               start_d;
  logic [7:0]         addr_d, data_d;
  logic               busy_d, done_d, err_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q           <= S_IDLE;
      o_rom_addr        <= '0;
      sccb.o_sccb_start <= 1'b0;
      sccb.o_sccb_addr  <= '0;
      sccb.o_sccb_data  <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
      retry_q           <= '0;
      cnt_q             <= '0;
    end else begin
      state_q           <= state_d;
      o_rom_addr        <= rom_addr_d;
      sccb.o_sccb_start <= start_d;
      sccb.o_sccb_addr  <= addr_d;
      sccb.o_sccb_data  <= data_d;
      o_busy            <= busy_d;
      o_done            <= done_d;
      o_err             <= err_d;
      retry_q           <= retry_d;
      cnt_q             <= cnt_d;
    end
  end

  // Next-state and output decode. The start pulse is registered from the
  // ready level seen on entry to / while in REQ, so it is visible during REQ
  // and REQ leaves on the cycle the pulse is high.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = o_rom_addr;
    start_d    = 1'b0;
    addr_d     = sccb.o_sccb_addr;
    data_d     = sccb.o_sccb_data;
    busy_d     = o_busy;
    done_d     = o_done;
    err_d      = o_err;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rom_addr_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (i_rom_data == END_MARK) begin
          state_d = S_DONE;
        end else if (i_rom_data == DELAY_MARK) begin
          cnt_d   = CNT_LOAD;
          state_d = S_DELAY;
        end else begin
          addr_d  = i_rom_data[15:8];
          data_d  = i_rom_data[7:0];
          retry_d = '0;
          start_d = sccb.i_sccb_ready;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sccb.o_sccb_start) begin
          state_d = S_WAIT;
        end else begin
          start_d = sccb.i_sccb_ready;
        end
      end
      S_WAIT: begin
        if (sccb.i_sccb_done) begin
          if (!sccb.i_sccb_nack) begin
            state_d = S_NEXT;
          end else if (retry_q != RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            start_d = sccb.i_sccb_ready;
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (o_rom_addr == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = o_rom_addr + 8'd1;
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cam_config_seq.sv
// Self-checking bench for cam_config_seq: ROM and SCCB master models driven
// with randomized timing, checked against a transaction-level write list.
module tb_cam_config_seq;

  localparam int unsigned CLK_FREQ  = 2000;
  localparam int unsigned DELAY_MS  = 10;
  localparam int unsigned MAX_RETRY = 3;
  localparam int          DELAY_CYC = 20;
  localparam int          BUDGET    = 20000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy, done, err;

  logic [15:0] rom [0:255];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         nd;
  } exp_t;
  exp_t expq[$];

  cam_config_seq_if sif ();

  cam_config_seq #(
    .CLK_FREQ (CLK_FREQ),
    .DELAY_MS (DELAY_MS),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .o_rom_addr(rom_addr),
    .i_rom_data(rom_data),
    .sccb      (sif),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_start"}, sif.o_sccb_start, 0);
    check({tag, "_addr"}, sif.o_sccb_addr, 0);
    check({tag, "_data"}, sif.o_sccb_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Expected write list: ROM order, markers removed, stop at end marker or 256.
  task automatic build_expected();
    exp_t e;
    int   nd;
    expq.delete();
    nd = 0;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) break;
      if (rom[a] == 16'hFFF0) begin
        nd++;
      end else begin
        e.a  = rom[a][15:8];
        e.d  = rom[a][7:0];
        e.nd = nd;
        expq.push_back(e);
        nd = 0;
      end
    end
  endtask

  task automatic gen_rom(input int n);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (i >= 6 && $urandom_range(0, 7) == 0) rom[i] = 16'hFFF0;
      else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
    end
  endtask

  task automatic drive_idle();
    start            = 1'b0;
    sif.i_sccb_ready = 1'b0;
    sif.i_sccb_done  = 1'b0;
    sif.i_sccb_nack  = 1'b0;
  endtask

  // One configuration pass with an SCCB master model and online scoreboard.
  task automatic run_pass(input int first_nack_idx, input int always_nack_idx,
                          input int nack_pct, input int long_pct, input bit check_lat,
                          input bit spurious, input int abort_starts);
    int  k, attempt, starts, phase, cnt, cycle, last_done, rise_cycle, prev_addr, extra;
    bit  exp_err, pend_nack, long_chk, in_range, ended;
    logic [7:0] hold_a, hold_d;
    k = 0; attempt = 0; starts = 0; cycle = 0; last_done = -1; rise_cycle = -1;
    prev_addr = 0; exp_err = 0; pend_nack = 0; long_chk = 0; ended = 0;
    hold_a = '0; hold_d = '0;
    build_expected();

    @(negedge clk);
    start = 1'b1;
    sif.i_sccb_done = 1'b0;
    sif.i_sccb_nack = 1'b0;
    sif.i_sccb_ready = check_lat;
    phase = check_lat ? 1 : 0;
    cnt = $urandom_range(0, 3);

    for (cycle = 1; cycle <= BUDGET; cycle++) begin
      @(negedge clk);
      start = 1'b0;
      sif.i_sccb_done = 1'b0;
      sif.i_sccb_nack = 1'b0;
      if (cycle == 1) begin
        check("busy_after_start", busy, 1);
        check("rom_addr_restart", rom_addr, 0);
      end
      if (busy !== 1'b1) begin
        ended = 1;
        break;
      end
      if (rom_addr !== 8'(prev_addr)) begin
        check("rom_addr_step", rom_addr, prev_addr + 1);
        prev_addr = int'(rom_addr);
      end

      if (sif.o_sccb_start === 1'b1) begin
        starts++;
        if (check_lat && starts == 1) check("first_start_latency", cycle, 3);
        if (long_chk) check("start_after_ready_rise", cycle, rise_cycle + 1);
        long_chk = 0;
        check("start_only_when_ready", phase, 1);
        in_range = (k < expq.size()) && !exp_err;
        check("start_expected", in_range, 1);
        if (in_range) begin
          check("write_addr", sif.o_sccb_addr, expq[k].a);
          check("write_data", sif.o_sccb_data, expq[k].d);
          if (attempt == 0 && last_done >= 0 && expq[k].nd > 0)
            check("delay_gap", (cycle - last_done) >= DELAY_CYC * expq[k].nd, 1);
        end
        hold_a = sif.o_sccb_addr;
        hold_d = sif.o_sccb_data;
        pend_nack = (k == always_nack_idx) || (k == first_nack_idx && attempt == 0) ||
                    ($urandom_range(0, 99) < nack_pct);
        sif.i_sccb_ready = 1'b0;
        phase = 2;
        cnt = $urandom_range(1, 6);
        if (abort_starts > 0 && starts == abort_starts) return;
      end else if (phase == 0) begin
        if (cnt == 0) begin
          sif.i_sccb_ready = 1'b1;
          rise_cycle = cycle;
          phase = 1;
        end else begin
          cnt--;
        end
        if (spurious && $urandom_range(0, 7) == 0) sif.i_sccb_done = 1'b1;
      end else if (phase == 2) begin
        check("addr_stable", sif.o_sccb_addr, hold_a);
        check("data_stable", sif.o_sccb_data, hold_d);
        if (cnt == 0) begin
          sif.i_sccb_done = 1'b1;
          sif.i_sccb_nack = pend_nack;
          last_done = cycle;
          if (!pend_nack) begin
            k++;
            attempt = 0;
          end else if (attempt == int'(MAX_RETRY)) begin
            exp_err = 1;
          end else begin
            attempt++;
          end
          phase = 0;
          if ($urandom_range(0, 99) < long_pct) begin
            cnt = 100;
            long_chk = !exp_err && (pend_nack ||
                       (k < expq.size() && expq[k].nd * DELAY_CYC + 10 < 100));
          end else begin
            cnt = $urandom_range(0, 4);
          end
        end else begin
          cnt--;
        end
      end
      if (spurious && $urandom_range(0, 15) == 0) start = 1'b1;
    end

    check("pass_terminated", ended, 1);
    check("done_flag", done, !exp_err);
    check("err_flag", err, exp_err);
    if (!exp_err) check("entries_written", k, expq.size());
    if (always_nack_idx >= 0) check("err_on_entry", k, always_nack_idx);

    // With ready high and no start, the finished sequencer must stay silent.
    extra = 0;
    sif.i_sccb_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (sif.o_sccb_start === 1'b1) extra++;
    end
    check("no_start_after_pass", extra, 0);
    check("still_idle", busy, 0);
    sif.i_sccb_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Small ROM with a delay marker, ready already high: latency and order.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    run_pass(-1, -1, 0, 0, 1'b1, 1'b0, 0);

    // Delay marker at address 0, single NACK on entry 2.
    gen_rom(30);
    rom[0] = 16'hFFF0;
    run_pass(2, -1, 0, 0, 1'b0, 1'b0, 0);

    // Entry 3 always NACKed: retries exhausted, error reported.
    gen_rom(30);
    run_pass(-1, 3, 0, 0, 1'b0, 1'b0, 0);

    // Random tables with random NACKs, long ready stalls and spurious pulses.
    for (int p = 0; p < 4; p++) begin
      gen_rom(20 + $urandom_range(0, 40));
      run_pass(-1, -1, 12, 15, 1'b0, 1'b1, 0);
    end

    // Reset while waiting for an SCCB completion, then a fresh pass.
    gen_rom(25);
    run_pass(-1, -1, 0, 0, 1'b0, 1'b0, 3);
    rst = 1'b1;
    drive_idle();
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("held_reset");
    rst = 1'b0;
    run_pass(-1, -1, 0, 10, 1'b0, 1'b0, 0);

    // No end marker anywhere: all 256 addresses written, address never wraps.
    for (int i = 0; i < 256; i++) rom[i] = 16'h0101;
    run_pass(-1, -1, 0, 0, 1'b0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_config_seq.md
Name: cam_config_seq

Overview:
- Sequencer that walks the OV7670 register-init ROM and issues one SCCB write per {reg addr, reg data} entry.
- Sits between the ROM (synchronous, 1-cycle read latency, 8-bit address, 16-bit data) and the SCCB master.
- Inserts a settle delay on the delay marker 16'hFF_F0 and finishes on the end marker 16'hFF_FF.
- Retries NACKed writes a bounded number of times; reports done/error to the top-level camera init logic.

Parameters:
- CLK_FREQ, 25_000_000, i_clk frequency in Hz.
- DELAY_MS, 10, settle time inserted on delay marker, in ms.
- MAX_RETRY, 3, extra attempts per entry after a NACK (0 = no retry).
- DELAY_CYC, CLK_FREQ/1000*DELAY_MS, derived localparam; counter width = $clog2(DELAY_CYC+1).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle pulse; begins a configuration pass from ROM address 0.
- o_rom_addr  out  8  ROM address.
- i_rom_data  in  16  ROM data {reg addr[15:8], reg data[7:0]}; valid one cycle after o_rom_addr changes.
- o_sccb_start  out  1  one-cycle write request to the SCCB master.
- o_sccb_addr  out  8  register address, held stable from start until done.
- o_sccb_data  out  8  register data, held stable from start until done.
- i_sccb_ready  in  1  SCCB master idle and able to accept a start.
- i_sccb_done  in  1  one-cycle pulse; the current transaction finished.
- i_sccb_nack  in  1  sampled with i_sccb_done; 1 = slave NACKed.
- o_busy  out  1  high from accepted i_start until DONE or ERROR.
- o_done  out  1  level; high after the end marker is reached with no error.
- o_err  out  1  level; high after retries are exhausted.

Behaviour:
- Reset (async, any state): state=IDLE, o_rom_addr=0, o_sccb_start=0, o_sccb_addr=0, o_sccb_data=0, o_busy=0, o_done=0, o_err=0, retry count=0, delay counter=0.
- IDLE:
  - On i_start: o_rom_addr=0, clear o_done/o_err, o_busy=1, go to FETCH.
  - Otherwise hold; o_done/o_err keep their previous values.
- FETCH: wait one cycle for ROM latency, then go to DECODE.
- DECODE (evaluates i_rom_data):
  - 16'hFF_FF: go to DONE.
  - 16'hFF_F0: load delay counter = DELAY_CYC-1, go to DELAY.
  - Any other value: latch o_sccb_addr/o_sccb_data, retry count=0, go to REQ.
- REQ:
  - When i_sccb_ready=1: pulse o_sccb_start for exactly one cycle, go to WAIT.
  - Otherwise stall indefinitely.
- WAIT: on i_sccb_done:
  - nack=0: go to NEXT.
  - nack=1 and retry count < MAX_RETRY: increment retry count, go to REQ (same addr/data).
  - nack=1 and retry count = MAX_RETRY: o_err=1, o_busy=0, go to IDLE.
- DELAY: decrement the counter each cycle; at 0 go to NEXT. Exactly DELAY_CYC cycles are spent in DELAY.
- NEXT:
  - If o_rom_addr==8'hFF: go to DONE (address never wraps to 0).
  - Otherwise o_rom_addr+1, go to FETCH.
- DONE: o_done=1, o_busy=0, go to IDLE.
- i_start is ignored while o_busy=1.
- i_sccb_done outside WAIT is ignored.
- Latency: i_start to the first o_sccb_start is 3 cycles when i_sccb_ready=1 (IDLE→FETCH→DECODE→REQ; start asserts in REQ).
- Reset mid-transaction aborts immediately and does not wait for the SCCB master.
- Delay marker at address 0 is legal.

Test Plan:
- ROM model {0:12_80, 1:FF_F0, 2:12_04, 3:FF_FF}, DELAY_CYC=20, ready tied 1, done 5 cycles after start → exactly two writes, (12,80) then (12,04); ≥20 cycles between the first done and the second start; o_done=1, o_busy=0, o_err=0.
- Full 76-entry camera table plus FF_FF default, DELAY_CYC=50 → 75 writes in ROM order matching the table, one delay, o_done=1; no start issued after the end marker.
- NACK on the first attempt of entry 2, MAX_RETRY=3 → entry 2 is written twice with identical addr/data; sequence continues; o_done=1.
- NACK on every attempt of entry 3, MAX_RETRY=3 → 4 starts for entry 3, then o_err=1, o_done=0, o_busy=0, and no further starts.
- i_sccb_ready held 0 for 100 cycles in REQ → no start and o_sccb_addr/data stable; start occurs the cycle after ready rises.
- i_rst asserted during WAIT, then deasserted, then i_start → all outputs are at reset values during reset; the pass restarts at address 0.
- ROM with no end marker (all 16'h01_01) → 256 writes at addresses 0..255, then o_done=1; o_rom_addr never returns to 0 mid-pass.
- Second i_start pulsed while busy → ignored; exactly one pass runs.
